// File: rtl/vga_sync_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_pkg
// Shared display timing constants, counter width, 3-bit colour codes and a
// small window-decode helper. The same package is imported by the VGA sync
// generator and by the background stage so both agree on the timing.
// -----------------------------------------------------------------------------
package vga_sync_gen_pkg;

  // Width of the pixel_x / pixel_y counters (800 and 525 both fit in 10 bits)
  localparam int CNT_W = 10;

  // Default 640x480 @ 60 Hz timing, in pixels (horizontal) and lines (vertical)
  localparam int H_DISPLAY_C = 640;
  localparam int H_FRONT_C   = 16;
  localparam int H_SYNC_C    = 96;
  localparam int H_BACK_C    = 48;
  localparam int V_DISPLAY_C = 480;
  localparam int V_FRONT_C   = 10;
  localparam int V_SYNC_C    = 2;
  localparam int V_BACK_C    = 33;

  // 3-bit colour codes {R,G,B} shared with the background stage
  typedef enum logic [2:0] {
    COL_BLACK   = 3'b000,
    COL_BLUE    = 3'b001,
    COL_GREEN   = 3'b010,
    COL_CYAN    = 3'b011,
    COL_RED     = 3'b100,
    COL_MAGENTA = 3'b101,
    COL_YELLOW  = 3'b110,
    COL_WHITE   = 3'b111
  } colour_e;

  // True when val lies in the inclusive window [lo, hi]
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    in_window = (val >= lo) && (val <= hi);
  endfunction

endpackage : vga_sync_gen_pkg

// File: rtl/vga_sync_gen_mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-N up counter with enable. Counts 0..MODULUS-1 and wraps to 0.
// Ports:
//   clk          - rising-edge clock
//   reset_n      - asynchronous active-low reset, clears the count
//   i_en         - advance the count on this edge
//   o_count      - current registered count
//   o_count_next - value the count will take on the next edge
//   o_wrap       - high on the enabled edge that wraps MODULUS-1 -> 0
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             w_at_last;

  // Next-count and wrap decode
  always_comb begin
    w_at_last = (r_count == LAST);
    o_wrap    = i_en && w_at_last;
    if (!i_en) begin
      o_count_next = r_count;
    end else if (w_at_last) begin
      o_count_next = ZERO;
    end else begin
      o_count_next = r_count + ONE;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= ZERO;
    end else begin
      r_count <= o_count_next;
    end
  end

  assign o_count = r_count;

endmodule : mod_counter

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// VGA timing generator. A 1-bit divider produces a pixel strobe every second
// clk; horizontal and vertical mod_counters step on that strobe and the sync,
// visible-area and frame-start signals are decoded from them.
// Ports:
//   clk        - 50 MHz system clock
//   reset_n    - asynchronous active-low reset
//   hsync      - horizontal sync, active low, registered
//   vsync      - vertical sync, active low, registered
//   video_on   - current pixel is inside the visible area
//   p_tick     - pixel strobe, high one clk in two
//   pixel_x    - horizontal count
//   pixel_y    - vertical count
//   frame_tick - one-clk pulse at the start of vertical blanking
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_C,
  parameter int H_FRONT   = H_FRONT_C,
  parameter int H_SYNC    = H_SYNC_C,
  parameter int H_BACK    = H_BACK_C,
  parameter int V_DISPLAY = V_DISPLAY_C,
  parameter int V_FRONT   = V_FRONT_C,
  parameter int V_SYNC    = V_SYNC_C,
  parameter int V_BACK    = V_BACK_C
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_SYNC_LO  = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_HI  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LO  = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_HI  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] V_LAST_VIS = CNT_W'(V_DISPLAY - 1);

  logic             r_div;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_tick;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_x_next;
  logic             w_h_wrap;
  logic [CNT_W-1:0] w_y;
  logic [CNT_W-1:0] w_y_next;
  logic             w_v_wrap;

  // Pixel divider: toggles every clk, its value is the pixel strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= 1'b0;
    end else begin
      r_div <= ~r_div;
    end
  end

  mod_counter #(
    .WIDTH   (CNT_W),
    .MODULUS (H_TOTAL)
  ) u_h_cnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_en         (r_div),
    .o_count      (w_x),
    .o_count_next (w_x_next),
    .o_wrap       (w_h_wrap)
  );

  // The vertical counter steps only on the pixel edge where the line wraps
  mod_counter #(
    .WIDTH   (CNT_W),
    .MODULUS (V_TOTAL)
  ) u_v_cnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_en         (w_h_wrap),
    .o_count      (w_y),
    .o_count_next (w_y_next),
    .o_wrap       (w_v_wrap)
  );

  // Sync and frame-start registers; decoding the counters' next values keeps
  // each sync edge on the same clk as the count it belongs to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_hsync      <= ~in_window(w_x_next, H_SYNC_LO, H_SYNC_HI);
      r_vsync      <= ~in_window(w_y_next, V_SYNC_LO, V_SYNC_HI);
      r_frame_tick <= w_h_wrap && (w_y == V_LAST_VIS);
    end
  end

  assign p_tick     = r_div;
  assign pixel_x    = w_x;
  assign pixel_y    = w_y;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign frame_tick = r_frame_tick;
  assign video_on   = (w_x < H_VIS_END) && (w_y < V_VIS_END);

  // The frame wrap is implied by the vertical count; it has no other consumer
  logic w_unused;
  assign w_unused = w_v_wrap;

endmodule : vga_sync_gen

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Self-checking bench for vga_sync_gen using a reduced timing so several
// frames fit in a short run. Expected outputs come from an arithmetic model
// of elapsed clk edges since reset release.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int HD = 16, HF = 4, HS = 6, HB = 6;
  localparam int VD = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME_CLK = 2 * HT * VT;
  localparam int Y_MID = 7;

  logic       clk;
  logic       reset_n;
  logic       hsync, vsync, video_on, p_tick, frame_tick;
  logic [9:0] pixel_x, pixel_y;

  int n_cmp;
  int n_err;
  int n_edges;

  vga_sync_gen #(
    .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .p_tick     (p_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clk edges seen since reset released; cleared asynchronously with reset
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) n_edges <= 0;
    else          n_edges <= n_edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: one pixel tick per two clk edges, raster position is plain division
  task automatic check_all(input string tag);
    int ticks, ex, ey;
    logic ehs, evs, evid, eft;
    ticks = n_edges / 2;
    ex    = ticks % HT;
    ey    = (ticks / HT) % VT;
    ehs   = !((ex >= HD + HF) && (ex < HD + HF + HS));
    evs   = !((ey >= VD + VF) && (ey < VD + VF + VS));
    evid  = (ex < HD) && (ey < VD);
    eft   = (n_edges > 0) && (n_edges % 2 == 0) && (ex == 0) && (ey == VD);
    check({tag, ".x"},   {22'd0, pixel_x}, ex);
    check({tag, ".y"},   {22'd0, pixel_y}, ey);
    check({tag, ".pt"},  {31'd0, p_tick}, n_edges % 2);
    check({tag, ".hs"},  {31'd0, hsync}, {31'd0, ehs});
    check({tag, ".vs"},  {31'd0, vsync}, {31'd0, evs});
    check({tag, ".vid"}, {31'd0, video_on}, {31'd0, evid});
    check({tag, ".ft"},  {31'd0, frame_tick}, {31'd0, eft});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".x"},   {22'd0, pixel_x}, 32'd0);
    check({tag, ".y"},   {22'd0, pixel_y}, 32'd0);
    check({tag, ".pt"},  {31'd0, p_tick}, 32'd0);
    check({tag, ".hs"},  {31'd0, hsync}, 32'd1);
    check({tag, ".vs"},  {31'd0, vsync}, 32'd1);
    check({tag, ".vid"}, {31'd0, video_on}, 32'd1);
    check({tag, ".ft"},  {31'd0, frame_tick}, 32'd0);
  endtask

  // Assert reset between edges, check asynchronously, hold, release on negedge
  task automatic async_reset(input string tag, input int hold);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals(tag);
    repeat (hold) begin
      @(negedge clk);
      check_reset_vals({tag, ".hold"});
    end
    reset_n = 1'b1;
  endtask

  initial begin
    int hs_low, first_hs_x, ft_cnt, vs_low, last_ft, y_max;
    bit found;
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check_reset_vals("rst");
    end
    reset_n = 1'b1;

    // Free run three frames with structural measurements alongside the model
    hs_low = 0; first_hs_x = -1; ft_cnt = 0; vs_low = 0; last_ft = -1; y_max = 0;
    for (int c = 0; c < 3 * FRAME_CLK + 8; c++) begin
      @(negedge clk);
      check_all("run");
      if (c < 2 * HT && hsync == 1'b0) begin
        if (first_hs_x < 0) first_hs_x = int'(pixel_x);
        hs_low++;
      end
      if (c < FRAME_CLK && vsync == 1'b0) vs_low++;
      if (int'(pixel_y) > y_max) y_max = int'(pixel_y);
      if (frame_tick == 1'b1) begin
        ft_cnt++;
        if (last_ft < 0) check("ft_first_y", {22'd0, pixel_y}, VD);
        else             check("ft_spacing", c - last_ft, FRAME_CLK);
        last_ft = c;
      end
      if (pixel_x == 10'(HD - 1) && pixel_y == 10'(VD - 1))
        check("vid_corner", {31'd0, video_on}, 32'd1);
    end
    check("hs_low_clks", hs_low, 2 * HS);
    check("hs_first_x", first_hs_x, HD + HF);
    check("vs_low_clks", vs_low, 2 * VS * HT);
    check("ft_count", ft_cnt, 3);
    check("y_max", y_max, VT - 1);

    // Reset mid-frame at a known line, then counting restarts from (0,0)
    found = 1'b0;
    for (int c = 0; c < 2 * FRAME_CLK && !found; c++) begin
      @(negedge clk);
      check_all("seek");
      if (pixel_y == 10'(Y_MID)) found = 1'b1;
    end
    check("seek_y_found", {31'd0, found}, 32'd1);
    async_reset("rst_mid", 2);
    for (int c = 0; c < 2 * HT + 4; c++) begin
      @(negedge clk);
      check_all("restart");
    end

    // Random run lengths with random asynchronous resets in between
    for (int it = 0; it < 6; it++) begin
      int len;
      len = int'($urandom_range(1, 3 * FRAME_CLK));
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        check_all("rand");
      end
      async_reset("rst_rand", int'($urandom_range(0, 4)));
    end
    for (int c = 0; c < FRAME_CLK; c++) begin
      @(negedge clk);
      check_all("tail");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_vga_sync_gen
